// File: rtl/clock_overlay_ctrl.sv
// Character-overlay controller: draws NUM_DIGITS BCD digits (plus optional colons) as
// 8x16 font-ROM glyphs at a fixed origin through a 3-stage registered pixel pipeline.
module clock_overlay_ctrl #(
  parameter int          NUM_DIGITS   = 6,
  parameter int          COLONS       = 1,
  parameter logic [9:0]  ORIGIN_X     = 10'd200,
  parameter logic [9:0]  ORIGIN_Y     = 10'd224,
  parameter logic [23:0] TEXT_COLOR   = 24'h00BF00,
  parameter logic [23:0] ALARM_COLOR  = 24'hBF0000,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                          disp_clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          count_set,
  input  logic [$clog2(NUM_DIGITS)-1:0] set_digit,
  input  logic                          alarm,
  input  logic [4*NUM_DIGITS-1:0]       bcd_digits,
  input  logic                          valid_draw,
  input  logic                          v_blank,
  input  logic [9:0]                    h_pos,
  input  logic [9:0]                    v_pos,
  output logic [10:0]                   rom_addr,
  input  logic [7:0]                    rom_data,
  output logic [7:0]                    disp_red,
  output logic [7:0]                    disp_green,
  output logic [7:0]                    disp_blue
);

  localparam int          NUM_SLOTS = NUM_DIGITS + COLONS * (NUM_DIGITS / 2 - 1);
  localparam logic [10:0] X_END     = {1'b0, ORIGIN_X} + 11'(8 * NUM_SLOTS);
  localparam logic [10:0] Y_END     = {1'b0, ORIGIN_Y} + 11'd16;
  localparam logic [7:0]  FC_LAST   = 8'(BLINK_FRAMES - 1);

  // Digit index shown in a slot, or -1 for a colon slot (pairs from the MSB end).
  function automatic int slot_digit(int s);
    if (COLONS == 0) return NUM_DIGITS - 1 - s;
    if ((s % 3) == 2) return -1;
    return NUM_DIGITS - 1 - ((s / 3) * 2 + (s % 3));
  endfunction

  logic [6:0]           slot_code [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_sel;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    localparam int D  = slot_digit(s);
    localparam int DS = (D < 0) ? 0 : D;
    logic [3:0] nib;
    assign nib          = bcd_digits[4*DS +: 4];
    assign slot_code[s] = (D < 0) ? 7'h3A : (nib <= 4'd9) ? (7'h30 + {3'b000, nib}) : 7'h20;
    assign slot_sel[s]  = (D >= 0) && (int'(set_digit) == D);
  end

  logic [9:0] dx;
  logic [3:0] glyph_row;
  logic       in_box_c;
  logic [6:0] char_c;
  logic       sel_c;

  // Range check on the raw coordinates first so pixels left of/above the origin never wrap in.
  always_comb begin
    in_box_c  = (h_pos >= ORIGIN_X) && ({1'b0, h_pos} < X_END) &&
                (v_pos >= ORIGIN_Y) && ({1'b0, v_pos} < Y_END);
    dx        = h_pos - ORIGIN_X;
    glyph_row = v_pos[3:0] - ORIGIN_Y[3:0];
    char_c    = 7'h20;
    sel_c     = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (dx[9:3] == 7'(s)) begin
        char_c = slot_code[s];
        sel_c  = slot_sel[s];
      end
    end
  end

  logic       s1_valid, s1_in_box, s1_sel, s1_en, s1_alarm, s1_set;
  logic [2:0] s1_col;
  logic       s2_valid, s2_in_box, s2_sel, s2_en, s2_alarm, s2_set;
  logic [2:0] s2_col;

  always_ff @(posedge disp_clock) begin
    if (reset) begin
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_in_box <= 1'b0;
      s1_sel    <= 1'b0;
      s1_en     <= 1'b0;
      s1_alarm  <= 1'b0;
      s1_set    <= 1'b0;
      s1_col    <= '0;
      s2_valid  <= 1'b0;
      s2_in_box <= 1'b0;
      s2_sel    <= 1'b0;
      s2_en     <= 1'b0;
      s2_alarm  <= 1'b0;
      s2_set    <= 1'b0;
      s2_col    <= '0;
    end else begin
      rom_addr  <= in_box_c ? {char_c, glyph_row} : 11'd0;
      s1_valid  <= valid_draw;
      s1_in_box <= in_box_c;
      s1_sel    <= in_box_c & sel_c;
      s1_en     <= en;
      s1_alarm  <= alarm;
      s1_set    <= count_set;
      s1_col    <= dx[2:0];
      s2_valid  <= s1_valid;
      s2_in_box <= s1_in_box;
      s2_sel    <= s1_sel;
      s2_en     <= s1_en;
      s2_alarm  <= s1_alarm;
      s2_set    <= s1_set;
      s2_col    <= s1_col;
    end
  end

  logic       vb_q;
  logic [7:0] frame_cnt;
  logic       blink_phase;

  // A rising v_blank closes a frame; blink_phase flips every BLINK_FRAMES frames.
  always_ff @(posedge disp_clock) begin
    if (reset) begin
      vb_q        <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vb_q <= v_blank;
      if (v_blank && !vb_q) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  logic [23:0] text_rgb, rgb_next, rgb_q;
  logic        visible, pixel_on;

  always_comb begin
    text_rgb = s2_alarm ? ALARM_COLOR : TEXT_COLOR;
    visible  = 1'b1;
    if (s2_alarm)               visible = blink_phase;
    else if (s2_set && s2_sel)  visible = blink_phase;
    pixel_on = s2_in_box & rom_data[3'd7 - s2_col] & visible;
    rgb_next = pixel_on ? text_rgb : BG_COLOR;
    if (!s2_en || !s2_valid) rgb_next = 24'h000000;
  end

  always_ff @(posedge disp_clock) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_next;
  end

  assign disp_red   = rgb_q[23:16];
  assign disp_green = rgb_q[15:8];
  assign disp_blue  = rgb_q[7:0];

endmodule
